// File: rtl/edge_colour_checker_if.sv
// rtl/edge_colour_checker_if.sv - memory read port between the edge/colour memory and the checker
//
// Purpose: bundles the read-only memory bus the checker borrows while busy.
// Signals:
//   mem_req  - checker owns the memory address port while high
//   addr     - 8-bit read address, registered inside the checker
//   rdata    - 8-bit read data, combinational from addr
// Modports:
//   master   - the checker (drives mem_req/addr, samples rdata)
//   slave    - the memory side (samples mem_req/addr, drives rdata)
interface edge_colour_checker_if;
  logic       mem_req;
  logic [7:0] addr;
  logic [7:0] rdata;

  modport master (output mem_req, output addr, input rdata);
  modport slave  (input mem_req, input addr, output rdata);
endinterface

// File: rtl/edge_colour_checker.sv
// rtl/edge_colour_checker.sv - read-only scanner that validates a vertex colouring against an edge list
//
// Purpose: on start, walks edge words from EDGE_BASE up to the TILDE terminator,
// fetches both endpoint colours from COLOR_BASE+v and reports OK, the first
// conflicting edge, the first uncoloured vertex, or a missing terminator.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   start      - begin a scan, only sampled while idle
//   mem        - memory read port (master side): mem_req, addr, rdata
//   busy       - scan in progress
//   done       - one-cycle pulse when result/fault_*/edge_count become valid
//   result     - 00 OK, 01 CONFLICT, 10 UNCOLOURED, 11 OVERRUN
//   fault_addr - address whose data ended the scan
//   fault_data - data at fault_addr
//   edge_count - number of edges that passed
module edge_colour_checker #(
  parameter logic [7:0] EDGE_BASE  = 8'd16,
  parameter logic [7:0] COLOR_BASE = 8'd0,
  parameter logic [7:0] TILDE      = 8'h7E
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  edge_colour_checker_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result,
  output logic [7:0]            fault_addr,
  output logic [7:0]            fault_data,
  output logic [6:0]            edge_count
);

  // Highest address an edge word may occupy; reaching it without a
  // terminator means the list overran its region.
  localparam logic [7:0] LAST_EDGE = 8'd127;

  localparam logic [1:0] RES_OK         = 2'b00;
  localparam logic [1:0] RES_CONFLICT   = 2'b01;
  localparam logic [1:0] RES_UNCOLOURED = 2'b10;
  localparam logic [1:0] RES_OVERRUN    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_COLA,
    S_COLB,
    S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [7:0] addr_q, addr_nx;
  logic [7:0] ptr, ptr_nx;
  logic [7:0] edge_word, edge_word_nx;
  logic [1:0] ca, ca_nx;
  logic [1:0] result_q, result_nx;
  logic [7:0] fault_addr_q, fault_addr_nx;
  logic [7:0] fault_data_q, fault_data_nx;
  logic [6:0] edge_count_q, edge_count_nx;
  logic       colour_ok;

  // Only 0..3 are real colours; TILDE and every other value mean "uncoloured".
  assign colour_ok = (mem.rdata[7:2] == 6'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      addr_q       <= 8'd0;
      ptr          <= EDGE_BASE;
      edge_word    <= 8'd0;
      ca           <= 2'd0;
      result_q     <= RES_OK;
      fault_addr_q <= 8'd0;
      fault_data_q <= 8'd0;
      edge_count_q <= 7'd0;
    end else begin
      state        <= state_nx;
      addr_q       <= addr_nx;
      ptr          <= ptr_nx;
      edge_word    <= edge_word_nx;
      ca           <= ca_nx;
      result_q     <= result_nx;
      fault_addr_q <= fault_addr_nx;
      fault_data_q <= fault_data_nx;
      edge_count_q <= edge_count_nx;
    end
  end

  // The address for each state is computed one state ahead and registered,
  // so addr is stable for the whole cycle the state evaluates rdata.
  always_comb begin
    state_nx      = state;
    addr_nx       = addr_q;
    ptr_nx        = ptr;
    edge_word_nx  = edge_word;
    ca_nx         = ca;
    result_nx     = result_q;
    fault_addr_nx = fault_addr_q;
    fault_data_nx = fault_data_q;
    edge_count_nx = edge_count_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          ptr_nx        = EDGE_BASE;
          addr_nx       = EDGE_BASE;
          edge_count_nx = 7'd0;
          state_nx      = S_EDGE;
        end
      end

      S_EDGE: begin
        if (mem.rdata == TILDE) begin
          result_nx     = RES_OK;
          fault_addr_nx = addr_q;
          fault_data_nx = mem.rdata;
          state_nx      = S_DONE;
        end else begin
          edge_word_nx = mem.rdata;
          addr_nx      = COLOR_BASE + {4'd0, mem.rdata[7:4]};
          state_nx     = S_COLA;
        end
      end

      S_COLA: begin
        if (!colour_ok) begin
          result_nx     = RES_UNCOLOURED;
          fault_addr_nx = addr_q;
          fault_data_nx = mem.rdata;
          state_nx      = S_DONE;
        end else begin
          ca_nx    = mem.rdata[1:0];
          addr_nx  = COLOR_BASE + {4'd0, edge_word[3:0]};
          state_nx = S_COLB;
        end
      end

      S_COLB: begin
        if (!colour_ok) begin
          result_nx     = RES_UNCOLOURED;
          fault_addr_nx = addr_q;
          fault_data_nx = mem.rdata;
          state_nx      = S_DONE;
        end else if (mem.rdata[1:0] == ca) begin
          // A conflict is reported against the edge, not the colour slot.
          result_nx     = RES_CONFLICT;
          fault_addr_nx = ptr;
          fault_data_nx = edge_word;
          state_nx      = S_DONE;
        end else begin
          edge_count_nx = edge_count_q + 7'd1;
          if (ptr == LAST_EDGE) begin
            result_nx     = RES_OVERRUN;
            fault_addr_nx = ptr;
            fault_data_nx = edge_word;
            state_nx      = S_DONE;
          end else begin
            ptr_nx   = ptr + 8'd1;
            addr_nx  = ptr + 8'd1;
            state_nx = S_EDGE;
          end
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign busy        = (state == S_EDGE) || (state == S_COLA) || (state == S_COLB);
  assign done        = (state == S_DONE);
  assign mem.mem_req = busy;
  assign mem.addr    = addr_q;
  assign result      = result_q;
  assign fault_addr  = fault_addr_q;
  assign fault_data  = fault_data_q;
  assign edge_count  = edge_count_q;

endmodule

// File: doc/edge_colour_checker.md
# edge_colour_checker

Read-only scanner that sits directly downstream of the edge/colour memory in the four-colour solver. On `start` it walks the edge list from `EDGE_BASE` until the `TILDE` terminator. For each edge it fetches both endpoint colours from the colour slots at `COLOR_BASE` and checks that the colours differ. It reports OK, the first conflicting edge, the first uncoloured vertex, or a missing terminator. Its result gates the solver's backtrack/accept decision.

## Interface
Parameters:
- `EDGE_BASE`, 8'd16: address of first edge word.
- `COLOR_BASE`, 8'd0: address of vertex 0 colour slot; vertex v colour is at `COLOR_BASE+v`.
- `TILDE`, 8'h7E: empty/terminator marker.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `start` input 1: begin scan. Sampled only in IDLE.
- `mem_req` output 1: equals `busy`. Top-level mux hands the memory address port to this block while high.
- `addr` output 8: memory address, registered.
- `rdata` input 8: memory read data. Combinational read, valid in the same cycle as `addr`.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `result` output 2: 00 OK, 01 CONFLICT, 10 UNCOLOURED, 11 OVERRUN.
- `fault_addr` output 8: address whose data ended the scan. Holds the terminator address on OK.
- `fault_data` output 8: data at `fault_addr`.
- `edge_count` output 7: number of edges that passed the check.

## Operation
- Edge word: vertex a = `rdata[7:4]`, vertex b = `rdata[3:0]`. A colour is legal only if it is in the range 0..3; any other value, including `TILDE`, counts as uncoloured.
- FSM states and transitions:
  - IDLE: on `start`, set `ptr` = `EDGE_BASE`, clear `edge_count`, go to EDGE.
  - EDGE: `addr` = `ptr`. If `rdata` == `TILDE`, set result OK and go to DONE. Otherwise latch a/b into a register and go to COLA.
  - COLA: `addr` = `COLOR_BASE+a`. If the colour is illegal, set UNCOLOURED and go to DONE. Otherwise latch `ca` and go to COLB.
  - COLB: `addr` = `COLOR_BASE+b`. Checks in priority order:
    - illegal colour: UNCOLOURED, go to DONE;
    - colour equals `ca`: CONFLICT, with `fault_addr` = `ptr` and `fault_data` = edge word, go to DONE;
    - otherwise increment `edge_count`. If `ptr` == 8'd127, set OVERRUN and go to DONE; else increment `ptr` and go to EDGE.
  - DONE: `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- `fault_addr`/`fault_data` on UNCOLOURED: the colour slot address and its content. On OVERRUN: 8'd127 and its edge word.
- `addr` is driven so that it is stable for the whole state cycle. The block never writes memory.
- `start` while busy is ignored. `result`, `fault_*` and `edge_count` hold until the next accepted `start`.
- A vertex nibble of 8..15 is legal and addresses colour slots 8..15.

## Timing
- Reset values (asynchronous, on `rst`=0): state IDLE, `addr`=0, `busy`=0, `mem_req`=0, `done`=0, `result`=00, `fault_addr`=0, `fault_data`=0, `edge_count`=0, `ptr`=`EDGE_BASE`.
- Reset mid-scan aborts immediately with no `done` pulse. After release the block idles until a new `start`.
- Let t0 be the rising edge at which `start` is accepted:
  - `busy` is high from t0.
  - Each state lasts exactly one cycle, so each edge costs 3 cycles.
  - For N passing edges followed by the terminator, `done` rises after edge t0+3N+1.
  - A fault on edge index k (0-based) in COLA gives `done` after t0+3k+2; in COLB, after t0+3k+3.
  - OVERRUN with the default base gives `done` after t0+336.
- `result`, `fault_*` and `edge_count` are valid in the same cycle as `done` and thereafter.

## Test plan
- **Default edges, all OK.** Load edges at 16..28 with terminator at 29; colours v0..v7 = 0,2,0,2,1,0,2,1. Pulse `start` → `done` 40 cycles later, `result`=00, `edge_count`=13, `fault_addr`=29, `fault_data`=8'h7E.
- **Conflict.** Same setup with v7 colour = 0 → CONFLICT, `fault_addr`=22, `fault_data`=8'h27, `edge_count`=6, `done` at t0+21.
- **Uncoloured.** Memory freshly reset (all colour slots 8'h7E) → UNCOLOURED, `fault_addr`=0, `fault_data`=8'h7E, `edge_count`=0, `done` at t0+2.
- **Overrun.** Addresses 16..127 all hold 8'h01; v0=0, v1=1 → OVERRUN, `edge_count`=112, `fault_addr`=127, `done` at t0+336.
- **Reset and re-start.** Assert `rst` low during COLA of edge 3 → all outputs return to reset values immediately, with no `done`. Release and start again → the full scan matches the first scenario exactly.
- **Start while busy.** Pulse `start` during the scan → ignored; timing and result are identical to the first scenario.
